traffic_monitor: RTL and testbench

// Receive side of the lamp-drive interface: samples the 4 lamp lines produced by the microcoded

---
 rtl/traffic_mon_pkg.sv | 28 ++
 rtl/traffic_mon_if.sv | 21 ++
 rtl/traffic_mon_lamp_filter.sv | 35 +++
 rtl/traffic_monitor.sv | 124 ++++++++++++
 tb/tb_traffic_monitor.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/traffic_mon_pkg.sv
// traffic_mon_pkg: phase encodings, fault codes, lamp bit positions and legal lamp patterns
package traffic_mon_pkg;
   typedef enum logic [2:0] {
      PH_UNKNOWN = 3'd0,
      PH_A_GO    = 3'd1,
      PH_CLEAR   = 3'd2,
      PH_B_GO    = 3'd3,
      PH_FAULT   = 3'd4
   } phase_t;
   typedef enum logic [1:0] {GO_NONE, GO_A, GO_B} last_go_t;
   localparam logic [2:0] FLT_NONE     = 3'd0;
   localparam logic [2:0] FLT_ILLEGAL  = 3'd1;
   localparam logic [2:0] FLT_BAD_SEQ  = 3'd2;
   localparam logic [2:0] FLT_SHORT_GO = 3'd3;
   localparam logic [2:0] FLT_TIMEOUT  = 3'd4;
   localparam int L_A_RED   = 3;
   localparam int L_A_GREEN = 2;
   localparam int L_B_RED   = 1;
   localparam int L_B_GREEN = 0;
   localparam logic [3:0] LAMP_DARK  = 4'b0000;
   localparam logic [3:0] LAMP_A_GO  = (4'b1 << L_A_GREEN) | (4'b1 << L_B_RED);
   localparam logic [3:0] LAMP_B_GO  = (4'b1 << L_A_RED) | (4'b1 << L_B_GREEN);
   localparam logic [3:0] LAMP_CLEAR = (4'b1 << L_A_RED) | (4'b1 << L_B_RED);
   // Legal patterns map to their phase; anything else comes back as PH_UNKNOWN.
   function automatic phase_t decode(input logic [3:0] p);
      return p == LAMP_A_GO ? PH_A_GO : p == LAMP_B_GO ? PH_B_GO : p == LAMP_CLEAR ? PH_CLEAR : PH_UNKNOWN;
   endfunction
endpackage

// File: rtl/traffic_mon_if.sv
// traffic_mon_if: lamp inputs, fault clear and monitor results between sequencer side and monitor
interface traffic_mon_if;
   import traffic_mon_pkg::*;
   logic [3:0]  lamp;
   logic        clear_fault;
   phase_t      phase;
   logic        phase_done;
   phase_t      last_phase;
   logic [7:0]  last_dwell;
   logic        fault;
   logic [2:0]  fault_code;
   logic [15:0] cycle_count;
   modport master (
      output lamp, clear_fault,
      input  phase, phase_done, last_phase, last_dwell, fault, fault_code, cycle_count
   );
   modport slave (
      input  lamp, clear_fault,
      output phase, phase_done, last_phase, last_dwell, fault, fault_code, cycle_count
   );
endinterface

// File: rtl/traffic_mon_lamp_filter.sv
// traffic_mon_lamp_filter: 2-FF synchroniser plus run-length filter; accept pulses once per stable run
module traffic_mon_lamp_filter #(
   parameter int FILTER_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] lamp,
   output logic [3:0] pattern,
   output logic       accept
);
   localparam logic [4:0] N = 5'(FILTER_CYCLES);
   logic [3:0] sync1_q, sync2_q, cand_q, cnt_q, cnt_d;
   logic [4:0] run;
   // Run length including the current synced sample; saturates so a held pattern accepts only once.
   always_comb begin
      run = sync2_q == cand_q ? {1'b0, cnt_q} + 5'd1 : 5'd1;
      accept = run == N;
      cnt_d = run > N ? cnt_q : run[3:0];
      pattern = sync2_q;
   end
   // Synchroniser chain and run-length state.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cand_q <= '0;
         cnt_q <= '0;
      end else begin
         sync1_q <= lamp;
         sync2_q <= sync1_q;
         cand_q <= sync2_q;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/traffic_monitor.sv
// traffic_monitor: checks filtered lamp patterns against the two-way plan, measures dwell, latches faults.
// Define TRAFFIC_MON_CYCLE_CNT_EN to count completed A_GO->B_GO->A_GO cycles.
module traffic_monitor
   import traffic_mon_pkg::*;
#(
   parameter int PRE_SCALE       = 19,
   parameter int FILTER_CYCLES   = 4,
   parameter int MIN_GO_TICKS    = 8,
   parameter int MAX_PHASE_TICKS = 200
) (
   input  logic         clock,
   input  logic         reset,
   traffic_mon_if.slave bus
);
   localparam logic [7:0] MIN_T = 8'(MIN_GO_TICKS);
   localparam logic [7:0] MAX_T = 8'(MAX_PHASE_TICKS);
   logic [3:0]           pat;
   logic                 acc;
   phase_t               phase_q, phase_d, last_phase_q, last_phase_d, dec;
   last_go_t             last_go_q, last_go_d;
   logic [PRE_SCALE-1:0] pre_q, pre_d;
   logic [7:0]           dwell_q, dwell_d, dwell_inc, last_dwell_q, last_dwell_d;
   logic                 done_q, done_d, fault_q, fault_d;
   logic [2:0]           code_q, code_d, flt;
   logic                 tick, in_run, is_go, change, legal, tmo;
   traffic_mon_lamp_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_lamp_filter (
      .clock   (clock),
      .reset   (reset),
      .lamp    (bus.lamp),
      .pattern (pat),
      .accept  (acc)
   );
   // Phase FSM: classify the accepted pattern, pick the highest-priority fault, else advance the phase.
   always_comb begin
      dec = decode(pat);
      tick = &pre_q;
      dwell_inc = tick && dwell_q != 8'hFF ? dwell_q + 8'd1 : dwell_q;
      in_run = phase_q inside {PH_A_GO, PH_CLEAR, PH_B_GO};
      is_go = phase_q inside {PH_A_GO, PH_B_GO};
      change = acc && (phase_q == PH_UNKNOWN ? pat != LAMP_DARK : in_run && dec != phase_q);
      legal = is_go ? dec == PH_CLEAR :
              phase_q == PH_CLEAR ? (dec == PH_A_GO && last_go_q != GO_A) || (dec == PH_B_GO && last_go_q != GO_B) :
              1'b1;
      tmo = in_run && dwell_q == MAX_T;
      flt = change && dec == PH_UNKNOWN ? FLT_ILLEGAL :
            change && !legal ? FLT_BAD_SEQ :
            change && is_go && dwell_inc < MIN_T ? FLT_SHORT_GO :
            tmo ? FLT_TIMEOUT : FLT_NONE;
      phase_d = phase_q;
      last_go_d = last_go_q;
      pre_d = pre_q + 1'b1;
      dwell_d = dwell_inc;
      done_d = 1'b0;
      last_phase_d = last_phase_q;
      last_dwell_d = last_dwell_q;
      fault_d = fault_q;
      code_d = code_q;
      if (fault_q) begin
         if (bus.clear_fault) begin
            fault_d = 1'b0;
            code_d = FLT_NONE;
            phase_d = PH_UNKNOWN;
            last_go_d = GO_NONE;
            pre_d = '0;
            dwell_d = '0;
         end
      end else if (flt != FLT_NONE) begin
         fault_d = 1'b1;
         code_d = flt;
         phase_d = PH_FAULT;
      end else if (change) begin
         phase_d = dec;
         pre_d = '0;
         dwell_d = '0;
         last_go_d = dec == PH_A_GO ? GO_A : dec == PH_B_GO ? GO_B : last_go_q;
         done_d = in_run;
         last_phase_d = in_run ? phase_q : last_phase_q;
         last_dwell_d = in_run ? dwell_inc : last_dwell_q;
      end
   end
   // State, timing and fault registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         phase_q <= PH_UNKNOWN;
         last_go_q <= GO_NONE;
         pre_q <= '0;
         dwell_q <= '0;
         done_q <= 1'b0;
         last_phase_q <= PH_UNKNOWN;
         last_dwell_q <= '0;
         fault_q <= 1'b0;
         code_q <= FLT_NONE;
      end else begin
         phase_q <= phase_d;
         last_go_q <= last_go_d;
         pre_q <= pre_d;
         dwell_q <= dwell_d;
         done_q <= done_d;
         last_phase_q <= last_phase_d;
         last_dwell_q <= last_dwell_d;
         fault_q <= fault_d;
         code_q <= code_d;
      end
   end
`ifdef TRAFFIC_MON_CYCLE_CNT_EN
   logic [15:0] cyc_q, cyc_d;
   // A legal CLEAR->A_GO after a B_GO closes one full cycle; the counter wraps.
   always_comb cyc_d = cyc_q + 16'(flt == FLT_NONE && change && phase_q == PH_CLEAR && dec == PH_A_GO && last_go_q == GO_B);
   // Cycle counter register, cleared by reset only.
   always_ff @(posedge clock) begin
      if (reset) cyc_q <= '0;
      else cyc_q <= cyc_d;
   end
   assign bus.cycle_count = cyc_q;
`else
   assign bus.cycle_count = '0;
`endif
   assign bus.phase = phase_q;
   assign bus.phase_done = done_q;
   assign bus.last_phase = last_phase_q;
   assign bus.last_dwell = last_dwell_q;
   assign bus.fault = fault_q;
   assign bus.fault_code = code_q;
endmodule

// File: tb/tb_traffic_monitor.sv
// tb_traffic_monitor: directed vectors with hand-computed expectations for traffic_monitor
module tb_traffic_monitor;
   import traffic_mon_pkg::*;
   logic clock = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_pass = 0;
   int   done_cnt = 0;
   traffic_mon_if bus();
   traffic_monitor #(
      .PRE_SCALE       (2),
      .FILTER_CYCLES   (3),
      .MIN_GO_TICKS    (4),
      .MAX_PHASE_TICKS (20)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );
   always #5 clock = ~clock;
   // Count phase_done pulses midway between edges.
   always @(negedge clock) if (!reset && bus.phase_done) done_cnt++;
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #3;
   endtask
   task automatic clear();
      bus.clear_fault = 1'b1;
      cyc(1);
      bus.clear_fault = 1'b0;
   endtask
   initial begin
      logic [15:0] exp_cyc;
`ifdef TRAFFIC_MON_CYCLE_CNT_EN
      exp_cyc = 16'd1;
`else
      exp_cyc = 16'd0;
`endif
      reset = 1'b1;
      bus.lamp = 4'b0110;
      bus.clear_fault = 1'b0;
      cyc(3);
      check("rst_phase", bus.phase, PH_UNKNOWN);
      check("rst_fault", bus.fault, 0);
      check("rst_code", bus.fault_code, 0);
      check("rst_done", bus.phase_done, 0);
      check("rst_dwell", bus.last_dwell, 0);
      check("rst_cycles", bus.cycle_count, 0);
      reset = 1'b0;
      cyc(4);
      check("a_go_early", bus.phase, PH_UNKNOWN);
      cyc(1);
      check("a_go_5edges", bus.phase, PH_A_GO);
      check("a_go_nofault", bus.fault, 0);
      cyc(19);
      bus.lamp = 4'b1010;
      cyc(5);
      check("clr_phase", bus.phase, PH_CLEAR);
      check("a_done", bus.phase_done, 1);
      check("a_last_phase", bus.last_phase, PH_A_GO);
      check("a_last_dwell", bus.last_dwell, 6);
      cyc(19);
      bus.lamp = 4'b1001;
      cyc(5);
      check("b_phase", bus.phase, PH_B_GO);
      check("clr_done", bus.phase_done, 1);
      check("clr_last_phase", bus.last_phase, PH_CLEAR);
      check("clr_last_dwell", bus.last_dwell, 6);
      cyc(1);
      check("done_pulse_end", bus.phase_done, 0);
      bus.lamp = 4'b1111;
      cyc(1);
      bus.lamp = 4'b1001;
      cyc(6);
      bus.lamp = 4'b1111;
      cyc(2);
      bus.lamp = 4'b1001;
      cyc(8);
      check("glitch_phase", bus.phase, PH_B_GO);
      check("glitch_fault", bus.fault, 0);
      check("glitch_done_cnt", 16'(done_cnt), 2);
      bus.lamp = 4'b1010;
      cyc(5);
      check("b_clr_phase", bus.phase, PH_CLEAR);
      cyc(20);
      bus.lamp = 4'b0110;
      cyc(5);
      check("cycle_a_phase", bus.phase, PH_A_GO);
      check("cycle_count", bus.cycle_count, exp_cyc);
      cyc(3);
      bus.lamp = 4'b1010;
      cyc(5);
      check("short_fault", bus.fault, 1);
      check("short_code", bus.fault_code, FLT_SHORT_GO);
      check("short_phase", bus.phase, PH_FAULT);
      check("short_done_cnt", 16'(done_cnt), 4);
      clear();
      check("clr_f_phase", bus.phase, PH_UNKNOWN);
      check("clr_f_fault", bus.fault, 0);
      check("clr_f_code", bus.fault_code, 0);
      bus.lamp = 4'b0110;
      cyc(5);
      check("re_a_phase", bus.phase, PH_A_GO);
      cyc(19);
      bus.lamp = 4'b1010;
      cyc(5);
      check("re_clr_phase", bus.phase, PH_CLEAR);
      bus.lamp = 4'b0110;
      cyc(5);
      check("seq_code", bus.fault_code, FLT_BAD_SEQ);
      bus.lamp = 4'b1111;
      cyc(5);
      check("sticky_code", bus.fault_code, FLT_BAD_SEQ);
      clear();
      bus.lamp = 4'b1010;
      cyc(5);
      check("tmo_clr_phase", bus.phase, PH_CLEAR);
      cyc(80);
      check("tmo_not_yet", bus.fault, 0);
      cyc(1);
      check("tmo_fault", bus.fault, 1);
      check("tmo_code", bus.fault_code, FLT_TIMEOUT);
      clear();
      bus.lamp = 4'b1100;
      cyc(5);
      check("ill_code", bus.fault_code, FLT_ILLEGAL);
      clear();
      bus.lamp = 4'b0110;
      cyc(5);
      check("final_a_phase", bus.phase, PH_A_GO);
      check("final_done_cnt", 16'(done_cnt), 5);
      cyc(6);
      reset = 1'b1;
      cyc(1);
      check("mid_rst_phase", bus.phase, PH_UNKNOWN);
      check("mid_rst_done", bus.phase_done, 0);
      check("mid_rst_dwell", bus.last_dwell, 0);
      check("mid_rst_last", bus.last_phase, PH_UNKNOWN);
      check("mid_rst_cycles", bus.cycle_count, 0);
      reset = 1'b0;
      cyc(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
